sha256_feeder: RTL and testbench
================================

# sha256_feeder

Front end for the SHA-256 compression core `tumble`. Accepts a message as a byte stream, builds 512-bit blocks, applies SHA-256 padding (0x80, zeros, 64-bit big-endian bit length) and issues each block to one instantiated `tumble`. Chains the intermediate hash between blocks and presents the final 256-bit digest with a valid/ready handshake.

## Interface
- `LEN_W`, default 61: width of the message byte counter. Bit length = counter << 3, zero-extended to 64 bits.

- `clk`  in  1  clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset; also drives `tumble.rst`
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  feeder accepts a beat this cycle
- `s_data`  in  8  message byte
- `s_last`  in  1  beat is the final beat of the message
- `s_keep`  in  1  beat carries a byte; 0 is legal only with `s_last`=1 (empty tail or empty message)
- `d_valid`  out  1  digest valid
- `d_ready`  in  1  digest consumed
- `digest`  out  [7:0][31:0]  H0..H7; `digest[0]` = H0 (first word of the printed hash)

## Operation
- State: 64-byte block buffer, pointer `ptr` (0..63), byte counter, H[7:0], flags `pad_pend` (message ended, padding incomplete) and `one_done` (0x80 written).
- States: FILL, PAD, SEND, WAIT, DONE. Reset: FILL, H = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), ptr = 0, counter = 0, flags clear.
- FILL: `s_ready`=1. On an accepted beat with `s_keep`=1, write the byte to buf[ptr], increment ptr and the counter.
  - Not `s_last` and ptr was 63 -> SEND (non-final).
  - `s_last` -> set `pad_pend`. If ptr was 63 with a byte written -> SEND; otherwise -> PAD at the next free position.
  - `s_keep`=0 with `s_last` -> PAD without writing.
- PAD: one byte per cycle. Write 0x80 if `one_done`=0 (then set it), else 0x00.
  - `one_done` set and ptr = 56 -> write the 8-byte length to bytes 56..63 in the same cycle, mark the block final -> SEND.
  - ptr would pass 63 -> SEND (non-final) and resume PAD at ptr 0.
- Block-to-core mapping: word j = big-endian bytes 4j..4j+3, driven on `in_data` bits [32j+31:32j]. Byte n sits at `in_data[4*(n/4) + 3 - n%4]`.
- SEND: pulse `tumble.in_valid` for exactly one cycle -> WAIT. `state0..7` = H, held stable through WAIT because the core adds them at completion.
- WAIT: on the first cycle `tumble.out_valid`=1, H <= `out_res`, ptr <= 0, then:
  - final block -> DONE, with `digest` loaded from `out_res`;
  - else `pad_pend` -> PAD;
  - else -> FILL.
  - The core holds `out_valid` high until the next `in_valid`, so only the WAIT exit samples it.
- DONE: `d_valid`=1 and `digest` held. On `d_ready`: H <= IV, counter, flags and ptr cleared -> FILL.
- `s_ready`=0 in PAD, SEND, WAIT and DONE.
- Counter overflow past 2^LEN_W bytes wraps silently; such messages are unsupported and no error is flagged.

## Timing
- Reset values: `s_ready`=0 while `rst` is high, then 1 in the next cycle; `d_valid`=0; `digest`=0.
- `s_ready` and `d_valid` are decoded from registered state only. There is no combinational path from `s_valid` or `d_ready` to any output.
- Per block: 64 accepted bytes (or PAD cycles), 1 SEND cycle, then WAIT until `out_valid`, about 66 cycles. Correctness depends only on `out_valid`, never on a cycle count.
- The digest appears in the cycle after the final block's `out_valid` is sampled.
- Input bubbles (`s_valid`=0) stall FILL without side effects. Back-to-back messages are accepted from the cycle after the `d_ready` handshake.
- `rst` in any state aborts the message. Feeder and core return to reset values, and a partial digest is never output.

## Structure
- `sha256_pkg`: IV constants, the K round-constant table (shared with the core), the state enum, and a byte-to-`in_data` index function.
- One sub-module: `tumble`, instantiated once. Padding and buffering stay in this module.

## Test plan
- "abc" (3 bytes, random `s_valid` bubbles) -> one `in_valid` pulse; digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message (single beat `s_last`=1, `s_keep`=0) -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> two `in_valid` pulses; digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- 64 bytes of 0x00 -> second block on `in_data` is byte0 = 0x80, bytes 1..61 = 0, bytes 62..63 = 0x02 0x00; `state0..7` of that block equal the first block's `out_res`.
- "abc" then empty message, `d_ready` low for 10 cycles on the first -> `d_valid` and `digest` stable and `s_ready`=0 throughout; second digest is e3b0c442…, proving H is restored to IV.
- `rst` asserted for 2 cycles during WAIT of the 56-byte vector's first block, then "abc" -> no `d_valid` before ba7816bf…, and `d_valid`=0 during reset.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: constants and helpers shared by the feeder and the tumble core.
// Words are stored as [7:0][31:0] with index 0 holding H0 / word a.
package sha256_pkg;

  typedef enum logic [2:0] {
    FILL,
    PAD,
    SEND,
    WAIT,
    DONE
  } fsm_t;

  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Message byte n lands big-endian inside word n/4 of in_data.
  function automatic logic [5:0] byte_idx(input logic [5:0] n);
    return {n[5:2], ~n[1:0]};
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bs0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bs1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/tumble.sv
// tumble: iterative SHA-256 compression, one round per cycle.
// state0..7 must stay stable until out_valid; they are added at completion.
module tumble
  import sha256_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [511:0]     in_data,
  input  logic [31:0]      state0,
  input  logic [31:0]      state1,
  input  logic [31:0]      state2,
  input  logic [31:0]      state3,
  input  logic [31:0]      state4,
  input  logic [31:0]      state5,
  input  logic [31:0]      state6,
  input  logic [31:0]      state7,
  output logic             out_valid,
  output logic [7:0][31:0] out_res
);

  logic [7:0][31:0]  st;
  logic [7:0][31:0]  v_q, v_d, vn;
  logic [7:0][31:0]  res_q, res_d;
  logic [15:0][31:0] w_q, w_d, wn;
  logic [5:0]        rnd_q, rnd_d;
  logic              busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       t1, t2;

  assign st = {state7, state6, state5, state4,
               state3, state2, state1, state0};

  always_comb begin
    t1 = v_q[7] + bs1(v_q[4])
       + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
       + K[rnd_q] + w_q[0];
    t2 = bs0(v_q[0])
       + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    vn = {v_q[6:0], t1 + t2};
    vn[4] = v_q[3] + t1;
    // Sliding 16-word schedule window; w_q[0] is the current W[t].
    wn = {ss1(w_q[14]) + w_q[9] + ss0(w_q[1]) + w_q[0], w_q[15:1]};
  end

  always_comb begin
    busy_d      = busy_q;
    rnd_d       = rnd_q;
    v_d         = v_q;
    w_d         = w_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (in_valid) begin
      busy_d      = 1'b1;
      rnd_d       = 6'd0;
      v_d         = st;
      w_d         = in_data;
      out_valid_d = 1'b0;
    end else if (busy_q) begin
      v_d   = vn;
      w_d   = wn;
      rnd_d = rnd_q + 6'd1;
      if (rnd_q == 6'd63) begin
        busy_d      = 1'b0;
        out_valid_d = 1'b1;
        for (int i = 0; i < 8; i++) res_d[i] = st[i] + vn[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      rnd_q       <= '0;
      v_q         <= '0;
      w_q         <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      busy_q      <= busy_d;
      rnd_q       <= rnd_d;
      v_q         <= v_d;
      w_q         <= w_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = res_q;

endmodule

// File: rtl/sha256_feeder.sv
// sha256_feeder: byte-stream front end for the tumble SHA-256 core.
// Buffers and pads 512-bit blocks, chains H and returns the digest.
module sha256_feeder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 61
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  input  logic             s_keep,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [7:0][31:0] digest
);

  fsm_t             state_q, state_d;
  logic [63:0][7:0] buf_q, buf_d;
  logic [5:0]       ptr_q, ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0][31:0] h_q, h_d;
  logic [7:0][31:0] digest_q, digest_d;
  logic             pad_pend_q, pad_pend_d;
  logic             one_done_q, one_done_d;
  logic             final_q, final_d;
  logic             core_in_valid;
  logic             core_out_valid;
  logic [7:0][31:0] core_res;
  logic [63:0]      bitlen;

  assign bitlen = 64'(cnt_q) << 3;

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    h_d           = h_q;
    digest_d      = digest_q;
    pad_pend_d    = pad_pend_q;
    one_done_d    = one_done_q;
    final_d       = final_q;
    core_in_valid = 1'b0;
    unique case (state_q)
      FILL: begin
        if (s_valid) begin
          if (s_keep) begin
            buf_d[byte_idx(ptr_q)] = s_data;
            ptr_d = ptr_q + 6'd1;
            cnt_d = cnt_q + LEN_W'(1);
          end
          if (s_last) pad_pend_d = 1'b1;
          if (s_keep && ptr_q == 6'd63) state_d = SEND;
          else if (s_last)              state_d = PAD;
        end
      end
      PAD: begin
        buf_d[byte_idx(ptr_q)] = one_done_q ? 8'h00 : 8'h80;
        one_done_d = 1'b1;
        ptr_d      = ptr_q + 6'd1;
        if (one_done_q && ptr_q == 6'd56) begin
          for (int i = 0; i < 8; i++)
            buf_d[byte_idx(6'(56 + i))] = bitlen[8*(7-i) +: 8];
          final_d = 1'b1;
          state_d = SEND;
        end else if (ptr_q == 6'd63) begin
          state_d = SEND;
        end
      end
      SEND: begin
        core_in_valid = 1'b1;
        state_d       = WAIT;
      end
      WAIT: begin
        // out_valid stays high after completion, so only sample it here.
        if (core_out_valid) begin
          h_d   = core_res;
          ptr_d = 6'd0;
          if (final_q) begin
            digest_d = core_res;
            state_d  = DONE;
          end else if (pad_pend_q) begin
            state_d = PAD;
          end else begin
            state_d = FILL;
          end
        end
      end
      DONE: begin
        if (d_ready) begin
          h_d        = IV;
          cnt_d      = '0;
          ptr_d      = 6'd0;
          pad_pend_d = 1'b0;
          one_done_d = 1'b0;
          final_d    = 1'b0;
          state_d    = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      ptr_q      <= '0;
      cnt_q      <= '0;
      h_q        <= IV;
      digest_q   <= '0;
      pad_pend_q <= 1'b0;
      one_done_q <= 1'b0;
      final_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      h_q        <= h_d;
      digest_q   <= digest_d;
      pad_pend_q <= pad_pend_d;
      one_done_q <= one_done_d;
      final_q    <= final_d;
    end
  end

  // Every byte of a block is rewritten before it is sent.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign s_ready = !rst && state_q == FILL;
  assign d_valid = !rst && state_q == DONE;
  assign digest  = digest_q;

  tumble u_tumble (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (core_in_valid),
    .in_data   (buf_q),
    .state0    (h_q[0]),
    .state1    (h_q[1]),
    .state2    (h_q[2]),
    .state3    (h_q[3]),
    .state4    (h_q[4]),
    .state5    (h_q[5]),
    .state6    (h_q[6]),
    .state7    (h_q[7]),
    .out_valid (core_out_valid),
    .out_res   (core_res)
  );

endmodule

// File: tb/tb_sha256_feeder.sv
// tb_sha256_feeder: known-answer table, random messages against a
// software SHA-256 model, plus stall and abort sequences.
module tb_sha256_feeder;
  import sha256_pkg::K;

  typedef logic [7:0][31:0] h_t;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    string        msg;
    int           nblk;
    logic [255:0] exp;
  } vec_t;

  localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMP_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] L56_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] IV_F  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam string        S56   = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

  logic       clk = 1'b0;
  logic       rst, s_valid, s_ready, s_last, s_keep, d_valid, d_ready;
  logic [7:0] s_data;
  h_t         digest;

  int n_chk = 0;
  int n_pass = 0;
  int pulses = 0;
  logic [511:0] blk_data[$];
  h_t           blk_state[$];

  sha256_feeder dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_keep(s_keep),
    .d_valid(d_valid), .d_ready(d_ready), .digest(digest)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dut.u_tumble.in_valid) begin
      pulses++;
      blk_data.push_back(dut.u_tumble.in_data);
      blk_state.push_back({dut.u_tumble.state7, dut.u_tumble.state6,
                           dut.u_tumble.state5, dut.u_tumble.state4,
                           dut.u_tumble.state3, dut.u_tumble.state2,
                           dut.u_tumble.state1, dut.u_tumble.state0});
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] flat(input h_t h);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = h[i];
    return r;
  endfunction

  function automatic h_t unflat(input logic [255:0] f);
    h_t h;
    for (int i = 0; i < 8; i++) h[i] = f[255-32*i -: 32];
    return h;
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression of the 64 bytes starting at m[off].
  function automatic h_t compress(input h_t h, input bq_t m, input int off);
    logic [31:0] w[64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    h_t r;
    for (int t = 0; t < 16; t++)
      w[t] = {m[off+4*t], m[off+4*t+1], m[off+4*t+2], m[off+4*t+3]};
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    a = h[0]; b = h[1]; c = h[2]; d = h[3];
    e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    r[0] = h[0] + a; r[1] = h[1] + b; r[2] = h[2] + c; r[3] = h[3] + d;
    r[4] = h[4] + e; r[5] = h[5] + f; r[6] = h[6] + g; r[7] = h[7] + hh;
    return r;
  endfunction

  function automatic h_t sha(input bq_t m);
    bq_t p = m;
    logic [63:0] bl = 64'(m.size()) * 64'd8;
    h_t h = unflat(IV_F);
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    for (int o = 0; o < p.size(); o += 64) h = compress(h, p, o);
    return h;
  endfunction

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic put(input logic [7:0] d, input logic last, input logic keep, input int bub);
    logic ok = 1'b0;
    int   n = 0;
    repeat (bub) begin s_valid = 1'b0; @(posedge clk); #1; end
    s_valid = 1'b1; s_data = d; s_last = last; s_keep = keep;
    while (!ok && n < 1000) begin
      @(negedge clk); ok = s_ready; @(posedge clk); #1; n++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    if (!ok) begin
      n_chk++;
      $display("FAIL beat_timeout: s_ready 0 for %0d cycles, want 1", n);
    end
  endtask

  task automatic send_msg(input bq_t m, input int bubmax, input bit tail);
    for (int i = 0; i < m.size(); i++)
      put(m[i], (i == m.size() - 1) && !tail, 1'b1, $urandom_range(0, bubmax));
    if (m.size() == 0 || tail) put(8'h00, 1'b1, 1'b0, 0);
  endtask

  task automatic wait_dv(output logic ok);
    int n = 0;
    @(negedge clk);
    while (!d_valid && n < 3000) begin @(negedge clk); n++; end
    ok = d_valid;
    if (!ok) begin
      n_chk++;
      $display("FAIL dvalid_timeout: d_valid 0 for %0d cycles, want 1", n);
    end
  endtask

  task automatic get_digest(output h_t dg);
    logic ok;
    wait_dv(ok);
    dg = ok ? digest : 'x;
    d_ready = 1'b1; @(posedge clk); #1; d_ready = 1'b0;
  endtask

  task automatic run_msg(input string nm, input bq_t m, input int bubmax,
                         input bit tail, input logic [255:0] exp, input int nblk);
    h_t dg;
    pulses = 0;
    send_msg(m, bubmax, tail);
    get_digest(dg);
    check({nm, "_digest"}, flat(dg), exp);
    check({nm, "_blocks"}, pulses, nblk);
  endtask

  initial begin
    vec_t         tbl[3];
    bq_t          m;
    h_t           dg, d0;
    logic [511:0] exp_blk;
    logic [7:0]   eb[64];
    logic         ok;
    int           bad, n;
    int           lens[10] = '{55, 56, 63, 64, 119, 120, 0, 0, 0, 0};

    tbl[0] = '{"abc", 1, ABC_D};
    tbl[1] = '{"", 1, EMP_D};
    tbl[2] = '{S56, 2, L56_D};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    s_keep = 1'b0; d_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_d_valid", d_valid, 1'b0);
    check("rst_digest", digest, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1'b1);
    @(posedge clk); #1;

    foreach (tbl[i])
      run_msg($sformatf("vec%0d", i), s2q(tbl[i].msg), 2, 1'b0, tbl[i].exp, tbl[i].nblk);

    for (int i = 6; i < 10; i++) lens[i] = $urandom_range(0, 200);
    foreach (lens[i]) begin
      m.delete();
      repeat (lens[i]) m.push_back(8'($urandom));
      run_msg($sformatf("rnd%0d_len%0d", i, lens[i]), m, 3, 1'($urandom),
              flat(sha(m)), (lens[i] + 8) / 64 + 1);
    end

    // 64 zero bytes: padding lands entirely in a second block.
    m.delete();
    repeat (64) m.push_back(8'h00);
    blk_data.delete(); blk_state.delete();
    run_msg("zeros64", m, 0, 1'b0, flat(sha(m)), 2);
    foreach (eb[i]) eb[i] = 8'h00;
    eb[0] = 8'h80; eb[62] = 8'h02;
    for (int i = 0; i < 64; i++) exp_blk[8*(4*(i/4) + 3 - i%4) +: 8] = eb[i];
    check("zeros64_blk2_data", blk_data.size() >= 2 ? blk_data[1] : 'x, exp_blk);
    check("zeros64_blk2_state", blk_state.size() >= 2 ? flat(blk_state[1]) : 'x,
          flat(compress(unflat(IV_F), m, 0)));

    // Digest held while d_ready is low, then H must be back at IV.
    send_msg(s2q("abc"), 1, 1'b0);
    wait_dv(ok);
    d0 = digest; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (d_valid !== 1'b1 || digest !== d0 || s_ready !== 1'b0) bad++;
    end
    check("hold_stable_errs", bad, 0);
    check("hold_digest", flat(d0), ABC_D);
    d_ready = 1'b1; @(posedge clk); #1; d_ready = 1'b0;
    m.delete();
    run_msg("after_hold_empty", m, 0, 1'b0, EMP_D, 1);

    // Abort the 56-byte message while the core is busy on block one.
    pulses = 0;
    send_msg(s2q(S56), 0, 1'b0);
    n = 0;
    while (pulses < 1 && n < 200) begin @(negedge clk); n++; end
    check("abort_reached_wait", pulses >= 1, 1'b1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (d_valid !== 1'b0 || s_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    check("abort_rst_outputs_errs", bad, 0);
    run_msg("after_abort_abc", s2q("abc"), 1, 1'b0, ABC_D, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
